// File: rtl/fetch_stage.sv
// fetch_stage
//
// Instruction-fetch stage of the LEGv8 datapath. Holds the 64-bit PC, issues
// one word request at a time to instruction memory over a valid/ready
// handshake, and presents each fetched instruction together with its PC in a
// single-entry IF/ID slot. Taken branches redirect the PC to
// br_pc + (br_offset << 2) and squash whatever is in flight.
//
// Ports
//   clk              in   rising-edge clock
//   reset_n          in   asynchronous active-low reset
//   imem_req_valid   out  fetch request valid (decoded from registered state)
//   imem_req_ready   in   memory accepts the request this cycle
//   imem_addr        out  byte address of the request (the registered PC)
//   imem_resp_valid  in   instruction word returned
//   imem_resp_data   in   instruction word
//   id_valid         out  IF/ID slot holds an instruction
//   id_ready         in   decode consumes the slot this cycle
//   id_instruction   out  instruction held in the slot
//   id_pc            out  address of id_instruction
//   br_taken         in   redirect request (one-cycle pulse)
//   br_pc            in   PC of the taken branch
//   br_offset        in   sign-extended word offset of the branch

module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instruction,
    output logic [63:0] id_pc,
    input  logic        br_taken,
    input  logic [63:0] br_pc,
    input  logic [63:0] br_offset
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        FULL,
        DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        idValid_q, idValid_d;
    logic [31:0] idInstr_q, idInstr_d;
    logic [63:0] idPc_q, idPc_d;

    logic [63:0] brTarget;
    logic        reqOutstanding;

    // Branch offsets count words; shifting the full 64-bit value truncates
    // the top two bits, which is the intended wrap-around behaviour.
    assign brTarget = br_pc + (br_offset << 2);

    // A request is still owed a response after this edge if we are waiting
    // without one, draining without one, or a fresh request is accepted now.
    assign reqOutstanding = ((state_q == WAIT)  && !imem_resp_valid) ||
                            ((state_q == DRAIN) && !imem_resp_valid) ||
                            ((state_q == FETCH) && imem_req_ready);

    // Next-state logic. The normal flow runs first; a redirect then overrides
    // the PC, squashes the slot and discards any same-cycle response.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        idValid_d = idValid_q;
        idInstr_d = idInstr_q;
        idPc_d    = idPc_q;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    idInstr_d = imem_resp_data;
                    idPc_d    = pc_q;
                    idValid_d = 1'b1;
                    pc_d      = pc_q + 64'd4;
                    state_d   = FULL;
                end
            end
            FULL: begin
                if (id_ready) begin
                    idValid_d = 1'b0;
                    state_d   = FETCH;
                end
            end
            DRAIN: begin
                if (imem_resp_valid) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (br_taken && (state_q != IDLE)) begin
            pc_d      = brTarget;
            idValid_d = 1'b0;
            idInstr_d = idInstr_q;
            idPc_d    = idPc_q;
            state_d   = reqOutstanding ? DRAIN : FETCH;
        end
    end

    // State and slot registers, cleared immediately on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            idValid_q <= 1'b0;
            idInstr_q <= 32'h0;
            idPc_q    <= 64'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            idValid_q <= idValid_d;
            idInstr_q <= idInstr_d;
            idPc_q    <= idPc_d;
        end
    end

    assign imem_req_valid = (state_q == FETCH);
    assign imem_addr      = pc_q;
    assign id_valid       = idValid_q;
    assign id_instruction = idInstr_q;
    assign id_pc          = idPc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//
// Directed bench for fetch_stage with RESET_PC = 0x1000. Inputs change one
// time unit after each rising edge and outputs are checked at that point,
// so every check sees the state produced by the edge just taken.

module tb_fetch_stage;

    logic        clk;
    logic        reset_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instruction;
    logic [63:0] id_pc;
    logic        br_taken;
    logic [63:0] br_pc;
    logic [63:0] br_offset;

    int vectors;
    int miscompares;

    logic [31:0] instrWords [0:4];

    fetch_stage #(
        .RESET_PC(64'h1000)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_instruction  (id_instruction),
        .id_pc           (id_pc),
        .br_taken        (br_taken),
        .br_pc           (br_pc),
        .br_offset       (br_offset)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then step to just after the next rising edge.
    task automatic applyStimulus(input logic        reqReady,
                                 input logic        respValid,
                                 input logic [31:0] respData,
                                 input logic        idReady,
                                 input logic        brTaken,
                                 input logic [63:0] brPc,
                                 input logic [63:0] brOffset);
        imem_req_ready  = reqReady;
        imem_resp_valid = respValid;
        imem_resp_data  = respData;
        id_ready        = idReady;
        br_taken        = brTaken;
        br_pc           = brPc;
        br_offset       = brOffset;
        @(posedge clk);
        #1;
    endtask

    // One comparison: counts the vector and reports any miscompare.
    task automatic checkOutput(input string       tag,
                               input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Directed sequence covering reset, streaming, stalls, redirects and a
    // mid-operation reset.
    initial begin
        logic [63:0] expPc;

        vectors     = 0;
        miscompares = 0;
        instrWords[0] = 32'h8B02_0020;
        instrWords[1] = 32'hF840_0041;
        instrWords[2] = 32'hB400_0062;
        instrWords[3] = 32'h1400_0003;
        instrWords[4] = 32'hCB03_0084;

        reset_n         = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        id_ready        = 1'b0;
        br_taken        = 1'b0;
        br_pc           = 64'h0;
        br_offset       = 64'h0;

        #12;
        checkOutput("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        checkOutput("rst_addr",      imem_addr,               64'h1000);
        checkOutput("rst_id_valid",  {63'h0, id_valid},       64'h0);
        checkOutput("rst_id_instr",  {32'h0, id_instruction}, 64'h0);
        checkOutput("rst_id_pc",     id_pc,                   64'h0);

        // Leave reset: IDLE for one edge, then FETCH.
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 64'h0);
        checkOutput("first_req_valid", {63'h0, imem_req_valid}, 64'h1);
        checkOutput("first_addr",      imem_addr,               64'h1000);

        // Three back-to-back fetches, zero-wait memory, decode always ready.
        expPc = 64'h1000;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 64'h0);
            checkOutput("stream_wait_req",  {63'h0, imem_req_valid}, 64'h0);
            checkOutput("stream_wait_idv",  {63'h0, id_valid},       64'h0);
            applyStimulus(1'b1, 1'b1, instrWords[i], 1'b1, 1'b0, 64'h0, 64'h0);
            checkOutput("stream_full_idv",  {63'h0, id_valid},       64'h1);
            checkOutput("stream_full_pc",   id_pc,                   expPc);
            checkOutput("stream_full_ins",  {32'h0, id_instruction}, {32'h0, instrWords[i]});
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 64'h0);
            expPc = expPc + 64'd4;
            checkOutput("stream_fetch_idv", {63'h0, id_valid},       64'h0);
            checkOutput("stream_fetch_req", {63'h0, imem_req_valid}, 64'h1);
            checkOutput("stream_fetch_adr", imem_addr,               expPc);
        end

        // Decode stalls for 5 cycles; stray responses in FULL are ignored.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 64'h0);
        applyStimulus(1'b1, 1'b1, instrWords[3], 1'b0, 1'b0, 64'h0, 64'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 64'h0, 64'h0);
            checkOutput("stall_idv", {63'h0, id_valid},       64'h1);
            checkOutput("stall_ins", {32'h0, id_instruction}, {32'h0, instrWords[3]});
            checkOutput("stall_pc",  id_pc,                   64'h100C);
            checkOutput("stall_req", {63'h0, imem_req_valid}, 64'h0);
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 64'h0);
        checkOutput("unstall_idv",  {63'h0, id_valid},       64'h0);
        checkOutput("unstall_req",  {63'h0, imem_req_valid}, 64'h1);
        checkOutput("unstall_addr", imem_addr,               64'h1010);

        // Redirect while FULL: 0x2000 + (-2 << 2) = 0x1FF8, no drain needed.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 64'h0);
        applyStimulus(1'b1, 1'b1, instrWords[4], 1'b0, 1'b0, 64'h0, 64'h0);
        checkOutput("full_before_br", {63'h0, id_valid}, 64'h1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFE);
        checkOutput("brfull_idv",  {63'h0, id_valid},       64'h0);
        checkOutput("brfull_req",  {63'h0, imem_req_valid}, 64'h1);
        checkOutput("brfull_addr", imem_addr,               64'h1FF8);

        // Redirect while WAIT: 0x100 + (3 << 2) = 0x10C after draining.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 64'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 64'h100, 64'h3);
        checkOutput("brwait_req", {63'h0, imem_req_valid}, 64'h0);
        checkOutput("brwait_idv", {63'h0, id_valid},       64'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 64'h0);
        checkOutput("drain_req",  {63'h0, imem_req_valid}, 64'h0);
        applyStimulus(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 64'h0, 64'h0);
        checkOutput("drain_done_idv",  {63'h0, id_valid},       64'h0);
        checkOutput("drain_done_req",  {63'h0, imem_req_valid}, 64'h1);
        checkOutput("drain_done_addr", imem_addr,               64'h10C);
        checkOutput("drain_done_ins",  {32'h0, id_instruction}, {32'h0, instrWords[4]});

        // Redirect together with a response and id_ready: 0x3000 + 16.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 64'h0);
        applyStimulus(1'b0, 1'b1, 32'hBEEF_0001, 1'b1, 1'b1, 64'h3000, 64'h4);
        checkOutput("brresp_idv",  {63'h0, id_valid},       64'h0);
        checkOutput("brresp_ins",  {32'h0, id_instruction}, {32'h0, instrWords[4]});
        checkOutput("brresp_req",  {63'h0, imem_req_valid}, 64'h1);
        checkOutput("brresp_addr", imem_addr,               64'h3010);

        // Redirect on the cycle a request is accepted: must drain first.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 64'h4000, 64'h0);
        checkOutput("braccept_req", {63'h0, imem_req_valid}, 64'h0);
        applyStimulus(1'b0, 1'b1, 32'hBEEF_0002, 1'b0, 1'b0, 64'h0, 64'h0);
        checkOutput("braccept_done_req",  {63'h0, imem_req_valid}, 64'h1);
        checkOutput("braccept_done_addr", imem_addr,               64'h4000);

        // Memory not ready for 4 cycles: request and address held.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 64'h0);
            checkOutput("notready_req",  {63'h0, imem_req_valid}, 64'h1);
            checkOutput("notready_addr", imem_addr,               64'h4000);
        end

        // Asynchronous reset in the middle of the wait.
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_req",  {63'h0, imem_req_valid}, 64'h0);
        checkOutput("midrst_addr", imem_addr,               64'h1000);
        checkOutput("midrst_idv",  {63'h0, id_valid},       64'h0);
        checkOutput("midrst_pc",   id_pc,                   64'h0);
        reset_n = 1'b1;
        #1;
        checkOutput("postrst_idle_req", {63'h0, imem_req_valid}, 64'h0);
        applyStimulus(1'b0, 1'b1, 32'hFACE_0001, 1'b1, 1'b0, 64'h0, 64'h0);
        checkOutput("postrst_req",  {63'h0, imem_req_valid}, 64'h1);
        checkOutput("postrst_addr", imem_addr,               64'h1000);
        checkOutput("postrst_idv",  {63'h0, id_valid},       64'h0);
        applyStimulus(1'b0, 1'b1, 32'hFACE_0002, 1'b1, 1'b0, 64'h0, 64'h0);
        checkOutput("late_resp_idv",  {63'h0, id_valid},       64'h0);
        checkOutput("late_resp_ins",  {32'h0, id_instruction}, 64'h0);
        checkOutput("late_resp_addr", imem_addr,               64'h1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
